// File: rtl/execute_exception_dispatch_pkg.sv
// Shared types for the execute exception dispatch block: FSM state encoding,
// event source, captured event payload and interrupt number codes.
package execute_exception_dispatch_pkg;

    localparam int unsigned NUM_W  = 7;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_REQ      = 2'd2,
        ST_WAIT_END = 2'd3
    } state_e;

    typedef enum logic {
        SRC_EXC = 1'b0,
        SRC_IRQ = 1'b1
    } src_e;

    // Captured event: number plus the two fault-info words.
    typedef struct packed {
        logic [NUM_W-1:0]  num;
        logic [DATA_W-1:0] fi0r;
        logic [DATA_W-1:0] fi1r;
    } event_t;

    localparam logic [NUM_W-1:0] INT_NUM_DOUBLE_FAULT = 7'h08;

endpackage

// File: rtl/exception_dispatch_vector_calc.sv
// Handler vector adder: vector_o = base_i + (num_i << P_VECTOR_SHIFT), mod 2^32.
// Ports: base_i (vector table base), num_i (event number), vector_o (combinational).
module exception_dispatch_vector_calc
    import execute_exception_dispatch_pkg::*;
#(
    parameter int unsigned P_VECTOR_SHIFT = 3
) (
    input  logic [DATA_W-1:0] base_i,
    input  logic [NUM_W-1:0]  num_i,
    output logic [DATA_W-1:0] vector_o
);

    // Carry out of bit 31 is discarded: the table base may wrap.
    assign vector_o = base_i + (DATA_W'(num_i) << P_VECTOR_SHIFT);

endmodule

// File: rtl/execute_exception_dispatch.sv
// Execute exception dispatch: arbitrates the execute-stage exception pulse
// against external IRQs, writes fault-info sysregs, pulses the pipeline hold,
// computes the handler vector and runs the REQ/ACK/END handshake with the
// event controller. One event in flight at a time.
// Ports: iCLOCK/iRESET_SYNC (sync active-high reset); iEXCEPT_* exception pulse;
// iIRQ_VALID/iIRQ_NUM/oIRQ_ACK IRQ request and combinational accept; iIDTR
// vector base; oSYSREG_FI_* fault-info write; oEVENT_* handshake and payload;
// oBUSY; oEVENT_COUNT saturating dispatched-event count.
// Optional: define EXCEPTION_DISPATCH_DOUBLE_FAULT_EN to turn exceptions seen
// outside IDLE into a pending double fault instead of dropping them.
module execute_exception_dispatch
    import execute_exception_dispatch_pkg::*;
#(
    parameter int unsigned P_VECTOR_SHIFT = 3,
    parameter int unsigned P_COUNT_W      = 16
) (
    input  logic                 iCLOCK,
    input  logic                 iRESET_SYNC,
    input  logic                 iEXCEPT_VALID,
    input  logic [NUM_W-1:0]     iEXCEPT_NUM,
    input  logic [DATA_W-1:0]    iEXCEPT_FI0R,
    input  logic [DATA_W-1:0]    iEXCEPT_FI1R,
    input  logic                 iIRQ_VALID,
    input  logic [NUM_W-1:0]     iIRQ_NUM,
    output logic                 oIRQ_ACK,
    input  logic [DATA_W-1:0]    iIDTR,
    output logic                 oSYSREG_FI_WE,
    output logic [DATA_W-1:0]    oSYSREG_FI0R,
    output logic [DATA_W-1:0]    oSYSREG_FI1R,
    output logic                 oEVENT_HOLD,
    output logic                 oEVENT_REQ,
    output logic [NUM_W-1:0]     oEVENT_NUM,
    output logic [DATA_W-1:0]    oEVENT_VECTOR,
    input  logic                 iEVENT_ACK,
    input  logic                 iEVENT_END,
    output logic                 oBUSY,
    output logic [P_COUNT_W-1:0] oEVENT_COUNT
);

    state_e                 state_q, state_d;
    src_e                   src_q, src_d;
    event_t                 evt_q, evt_d;
    logic [DATA_W-1:0]      vector_q, vector_d, vector_c;
    logic [P_COUNT_W-1:0]   count_q, count_d;
    logic                   fi_we_q, fi_we_d;
    logic                   hold_q, hold_d;
    logic                   req_q, req_d;
    logic                   busy_q, busy_d;
    logic                   irq_ack_c;
`ifdef EXCEPTION_DISPATCH_DOUBLE_FAULT_EN
    logic                   df_pend_q, df_pend_d;
    logic                   df_inflight_q, df_inflight_d;
    logic [NUM_W-1:0]       df_orig_q, df_orig_d;
`endif

    exception_dispatch_vector_calc #(
        .P_VECTOR_SHIFT (P_VECTOR_SHIFT)
    ) u_vector_calc (
        .base_i   (iIDTR),
        .num_i    (evt_q.num),
        .vector_o (vector_c)
    );

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        evt_d     = evt_q;
        vector_d  = vector_q;
        count_d   = count_q;
        irq_ack_c = 1'b0;
`ifdef EXCEPTION_DISPATCH_DOUBLE_FAULT_EN
        df_pend_d     = df_pend_q;
        df_inflight_d = df_inflight_q;
        df_orig_d     = df_orig_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef EXCEPTION_DISPATCH_DOUBLE_FAULT_EN
                // A pending double fault beats both a new exception and IRQs.
                if (df_pend_q) begin
                    evt_d         = '{num: INT_NUM_DOUBLE_FAULT, fi0r: DATA_W'(df_orig_q), fi1r: '0};
                    src_d         = SRC_EXC;
                    df_pend_d     = 1'b0;
                    df_inflight_d = 1'b1;
                    state_d       = ST_WRITE;
                end else
`endif
                if (iEXCEPT_VALID) begin
                    evt_d   = '{num: iEXCEPT_NUM, fi0r: iEXCEPT_FI0R, fi1r: iEXCEPT_FI1R};
                    src_d   = SRC_EXC;
                    state_d = ST_WRITE;
                end else if (iIRQ_VALID) begin
                    // IRQ leaves the captured FI words untouched.
                    evt_d.num = iIRQ_NUM;
                    irq_ack_c = 1'b1;
                    src_d     = SRC_IRQ;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                vector_d = vector_c;
                state_d  = ST_REQ;
            end
            ST_REQ: begin
                if (iEVENT_ACK) begin
                    state_d = ST_WAIT_END;
                    if (count_q != '1) begin
                        count_d = count_q + P_COUNT_W'(1);
                    end
                end
            end
            ST_WAIT_END: begin
                if (iEVENT_END) begin
                    state_d = ST_IDLE;
`ifdef EXCEPTION_DISPATCH_DOUBLE_FAULT_EN
                    df_inflight_d = 1'b0;
`endif
                end
            end
        endcase

`ifdef EXCEPTION_DISPATCH_DOUBLE_FAULT_EN
        // Nested exception: remember the interrupted event number once.
        if ((state_q != ST_IDLE) && iEXCEPT_VALID && !df_pend_q && !df_inflight_q) begin
            df_pend_d = 1'b1;
            df_orig_d = evt_q.num;
        end
`endif

        fi_we_d = (state_d == ST_WRITE) && (src_d == SRC_EXC);
        hold_d  = (state_d == ST_WRITE);
        req_d   = (state_d == ST_REQ);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q  <= ST_IDLE;
            src_q    <= SRC_EXC;
            evt_q    <= '0;
            vector_q <= '0;
            count_q  <= '0;
            fi_we_q  <= 1'b0;
            hold_q   <= 1'b0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef EXCEPTION_DISPATCH_DOUBLE_FAULT_EN
            df_pend_q     <= 1'b0;
            df_inflight_q <= 1'b0;
            df_orig_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            evt_q    <= evt_d;
            vector_q <= vector_d;
            count_q  <= count_d;
            fi_we_q  <= fi_we_d;
            hold_q   <= hold_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
`ifdef EXCEPTION_DISPATCH_DOUBLE_FAULT_EN
            df_pend_q     <= df_pend_d;
            df_inflight_q <= df_inflight_d;
            df_orig_q     <= df_orig_d;
`endif
        end
    end

    // IRQ accept is combinational; reset suppresses it.
    assign oIRQ_ACK      = irq_ack_c && !iRESET_SYNC;
    assign oSYSREG_FI_WE = fi_we_q;
    assign oSYSREG_FI0R  = evt_q.fi0r;
    assign oSYSREG_FI1R  = evt_q.fi1r;
    assign oEVENT_HOLD   = hold_q;
    assign oEVENT_REQ    = req_q;
    assign oEVENT_NUM    = evt_q.num;
    assign oEVENT_VECTOR = vector_q;
    assign oBUSY         = busy_q;
    assign oEVENT_COUNT  = count_q;

endmodule

// File: doc/execute_exception_dispatch.md
Name: execute_exception_dispatch

Overview:
- Downstream of the execute exception stage: consumes its one-cycle exception pulse (number, FI0R, FI1R) and arbitrates it against external IRQ requests.
- Writes fault-info system registers, pulses the pipeline hold, computes the vector address and runs a req/ack handshake with the event controller until the event ends.
- Only one event is in flight at a time.

Parameters:
- P_VECTOR_SHIFT, 3, log2 of vector-table entry size in bytes (vector = iIDTR + (num << P_VECTOR_SHIFT)).
- P_COUNT_W, 16, width of saturating dispatched-event counter.

Ports:
- iCLOCK  in  1  clock; all state updates on rising edge.
- iRESET_SYNC  in  1  reset, synchronous, active-high; only reset.
- iEXCEPT_VALID  in  1  exception pulse from execute exception stage.
- iEXCEPT_NUM  in  7  exception number.
- iEXCEPT_FI0R  in  32  fault info 0.
- iEXCEPT_FI1R  in  32  fault info 1.
- iIRQ_VALID  in  1  external interrupt request, level, held until acked.
- iIRQ_NUM  in  7  interrupt number.
- oIRQ_ACK  out  1  one-cycle accept of IRQ.
- iIDTR  in  32  vector table base.
- oSYSREG_FI_WE  out  1  write strobe for FI0R/FI1R.
- oSYSREG_FI0R  out  32  FI0R write data.
- oSYSREG_FI1R  out  32  FI1R write data.
- oEVENT_HOLD  out  1  one-cycle pipeline hold/flush pulse.
- oEVENT_REQ  out  1  event start request.
- oEVENT_NUM  out  7  event number, stable while REQ/WAIT_END.
- oEVENT_VECTOR  out  32  handler vector address, stable while REQ/WAIT_END.
- iEVENT_ACK  in  1  event controller accepts request.
- iEVENT_END  in  1  event sequence complete.
- oBUSY  out  1  state != IDLE.
- oEVENT_COUNT  out  P_COUNT_W  saturating count of dispatched events.

Behaviour:
- Reset (iRESET_SYNC=1 at edge, any state): state=IDLE; every output 0; captured num/FI/vector regs 0; counter 0. Overrides all other inputs, including mid-handshake.
- IDLE:
  - iEXCEPT_VALID=1: capture num/FI0R/FI1R, source=EXC, go WRITE.
  - Else iIRQ_VALID=1: capture iIRQ_NUM, oIRQ_ACK=1 combinationally this cycle, source=IRQ, go WRITE.
  - Simultaneous exception and IRQ: exception wins; IRQ not acked and stays pending.
- WRITE (exactly 1 cycle):
  - oEVENT_HOLD=1.
  - oSYSREG_FI_WE=1 only when source=EXC, with captured FI data; FI regs untouched for IRQ.
  - Register vector = iIDTR + ({25'h0,num} << P_VECTOR_SHIFT), mod 2^32 (wrap-around, no flag). iIDTR sampled in this cycle.
  - Go REQ.
- REQ: oEVENT_REQ=1 until iEVENT_ACK sampled 1; then go WAIT_END, counter +1, saturating at all-ones. iEVENT_ACK in any other state is ignored.
- WAIT_END: oEVENT_REQ=0; iEVENT_END=1 goes to IDLE. New events are accepted from IDLE the next cycle, giving a minimum 1-cycle gap.
- Latency, exception pulse at cycle N:
  - N+1: WRITE (WE, HOLD).
  - N+2: REQ asserted.
  - ACK at cycle M: WAIT_END from M+1.
- iEXCEPT_VALID while not IDLE: handled per optional feature. oIRQ_ACK never asserted outside IDLE.
- iEVENT_END while not WAIT_END: ignored.

Optional Feature:
- Macro: EXCEPTION_DISPATCH_DOUBLE_FAULT_EN.
- Defined:
  - iEXCEPT_VALID in WRITE, REQ or WAIT_END latches a sticky pending double fault (num=INT_NUM_DOUBLE_FAULT, FI0R=captured original num zero-extended, FI1R=0).
  - After return to IDLE it is dispatched before any IRQ, with source=EXC.
  - A further exception while the double fault is pending or in flight is dropped.
- Undefined: exceptions arriving outside IDLE are dropped silently; no extra state.

Decomposition:
- Shared package/include: state encoding localparams (IDLE, WRITE, REQ, WAIT_END), source enum (EXC/IRQ), INT_NUM_DOUBLE_FAULT (7'h08) alongside the existing INT_NUM_* codes.
- One natural sub-module: exception_dispatch_vector_calc (combinational base+shift adder, registered by parent).
- Counter and FSM stay in the top module.

Test Plan:
- Exception pulse, num=7'h05, FI0R=32'h0000_1000, FI1R=32'h9, iIDTR=32'h0000_8000:
  - N+1: WE=1 with FI0R/FI1R data, HOLD=1.
  - N+2: REQ=1, NUM=5, VECTOR=32'h0000_8028.
  - ACK: COUNT=1. END: BUSY=0.
- iIRQ_VALID, num=7'h20, no exception: oIRQ_ACK=1 in same cycle; WE stays 0; VECTOR=iIDTR+32'h100.
- Exception and IRQ same cycle: exception dispatched; oIRQ_ACK=0; IRQ dispatched once the first event's END returns the block to IDLE.
- iEVENT_ACK held low 10 cycles: REQ stays 1, NUM/VECTOR stable; iRESET_SYNC mid-REQ: next cycle all outputs 0, BUSY=0.
- iIDTR=32'hFFFF_FFF8, num=7'h01: VECTOR wraps to 32'h0000_0000. P_COUNT_W=2, 5 events: COUNT saturates at 3.
- Second exception during WAIT_END:
  - Macro defined: after END, double fault dispatched with NUM=7'h08, FI0R=original num.
  - Macro undefined: dropped, COUNT unchanged.
